// File: rtl/frequency_counter_gen2.sv
// Gated BCD frequency counter with multiplexed 7-seg display; define FREQ_COUNTER_DEBUG_EN to expose FSM state/edge.
// Latency: edges counted SYNC_STAGES+1 clocks after sampling; display updates on the clock ending LATCH.
// Backpressure: none; ena low freezes FSM, counters and mux while the synchroniser keeps running.
module frequency_counter_gen2 #(
   parameter int DIGITS      = 2,
   parameter int PERIOD_W    = 12,
   parameter int PERIOD_RST  = 1000,
   parameter int SYNC_STAGES = 2,
   parameter int MUX_DIV_W   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                signal,
   input  logic [PERIOD_W-1:0] period,
   input  logic                load_period,
   output logic [6:0]          seg,
   output logic [DIGITS-1:0]   digit_sel,
   output logic                overflow,
   output logic [1:0]          dbg_state,
   output logic                dbg_edge
);
   typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1, LATCH = 2'd2} state_t;
   localparam int BCD_W = 4 * DIGITS;

   state_t               state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 sync_prev, edge_pulse;
   logic [PERIOD_W-1:0]  period_reg, window_q;
   logic                 window_end;
   logic [BCD_W-1:0]     count_q, count_inc, display_reg;
   logic                 all_nines, ovf_flag;
   logic [MUX_DIV_W-1:0] mux_cnt;
   logic [1:0]           dig_idx;
   logic [3:0]           sel_bcd;

   // Synchroniser and compare flop run regardless of ena so no edge is half-seen on resume.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         sync_prev  <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], signal};
         sync_prev  <= sync_q[SYNC_STAGES-1];
         edge_pulse <= sync_q[SYNC_STAGES-1] & ~sync_prev;
      end
   end

   always_comb begin : bcd_inc
      logic carry;
      carry     = 1'b1;
      all_nines = 1'b1;
      count_inc = count_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (count_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
         if (carry) begin
            if (count_q[4*i +: 4] == 4'd9) begin
               count_inc[4*i +: 4] = 4'd0;
            end else begin
               count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
   end

   assign window_end = (window_q == period_reg - PERIOD_W'(2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= GATE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (ena) begin
         if (load_period) begin
            state_d = (period >= PERIOD_W'(2)) ? GATE : IDLE;
         end else begin
            case (state_q)
               IDLE:    state_d = IDLE;
               GATE:    if (window_end) state_d = LATCH;
               LATCH:   state_d = GATE;
               default: state_d = GATE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_reg  <= PERIOD_W'(PERIOD_RST);
         window_q    <= '0;
         count_q     <= '0;
         ovf_flag    <= 1'b0;
         display_reg <= '0;
         overflow    <= 1'b0;
      end else if (ena) begin
         if (load_period) begin
            period_reg <= period;
            window_q   <= '0;
            count_q    <= '0;
            ovf_flag   <= 1'b0;
         end else if (state_q == GATE) begin
            window_q <= window_q + PERIOD_W'(1);
            if (edge_pulse) begin
               if (all_nines) ovf_flag <= 1'b1;
               else           count_q  <= count_inc;
            end
         end else if (state_q == LATCH) begin
            display_reg <= count_q;
            overflow    <= ovf_flag;
            // An edge landing in LATCH opens the next window's count.
            count_q     <= {{(BCD_W-1){1'b0}}, edge_pulse};
            ovf_flag    <= 1'b0;
            window_q    <= '0;
         end else if (state_q != IDLE) begin
            window_q <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mux_cnt <= '0;
         dig_idx <= 2'd0;
      end else if (ena) begin
         mux_cnt <= mux_cnt + MUX_DIV_W'(1);
         if (&mux_cnt) dig_idx <= (dig_idx == 2'(DIGITS-1)) ? 2'd0 : dig_idx + 2'd1;
      end
   end

   always_comb begin
      digit_sel = '0;
      sel_bcd   = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_idx == 2'(i)) begin
            digit_sel[i] = 1'b1;
            sel_bcd      = display_reg[4*i +: 4];
         end
      end
   end

   always_comb begin
      case (sel_bcd)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = 7'h00;
      endcase
      if (overflow) seg = 7'h40;
   end

`ifdef FREQ_COUNTER_DEBUG_EN
   assign dbg_state = state_q;
   assign dbg_edge  = edge_pulse;
`else
   assign dbg_state = 2'b00;
   assign dbg_edge  = 1'b0;
`endif

endmodule

// File: tb/tb_frequency_counter_gen2.sv
// Directed bench for frequency_counter_gen2: window table plus IDLE, LATCH-edge, reset and ena sequences.
module tb_frequency_counter_gen2;
   localparam int DIGITS     = 2;
   localparam int PERIOD_W   = 12;
   localparam int PERIOD_RST = 1000;
`ifdef FREQ_COUNTER_DEBUG_EN
   localparam logic [1:0] GATE_ENC = 2'd1;
`else
   localparam logic [1:0] GATE_ENC = 2'd0;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                ena = 1'b0;
   logic                signal = 1'b0;
   logic                load_period = 1'b0;
   logic [PERIOD_W-1:0] period = '0;
   logic [6:0]          seg;
   logic [DIGITS-1:0]   digit_sel;
   logic                overflow;
   logic [1:0]          dbg_state;
   logic                dbg_edge;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int dbg_seen = 0;

   typedef struct {
      int period;
      bit reload;
      int n_edges;
      int half;
      int exp_val;
      bit exp_ovf;
   } vec_t;
   vec_t tbl[7];

   frequency_counter_gen2 #(
      .DIGITS(DIGITS), .PERIOD_W(PERIOD_W), .PERIOD_RST(PERIOD_RST),
      .SYNC_STAGES(2), .MUX_DIV_W(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .signal(signal), .period(period),
      .load_period(load_period), .seg(seg), .digit_sel(digit_sel),
      .overflow(overflow), .dbg_state(dbg_state), .dbg_edge(dbg_edge)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (dbg_state !== 2'b00 || dbg_edge !== 1'b0) dbg_seen <= dbg_seen + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] seg7(input int d);
      case (d)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [7:0] exp_seg(input int val, input logic ovf, input logic [DIGITS-1:0] dsel);
      if (dsel === 2'b01) return ovf ? 8'h40 : {1'b0, seg7(val % 10)};
      if (dsel === 2'b10) return ovf ? 8'h40 : {1'b0, seg7(val / 10)};
      return 8'hFF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic do_load(input int p, output int tl);
      period      = PERIOD_W'(p);
      load_period = 1'b1;
      tick();
      tl          = cyc;
      load_period = 1'b0;
   endtask

   task automatic pulse_train(input int n, input int half);
      for (int i = 0; i < n; i++) begin
         signal = 1'b1;
         repeat (half) tick();
         signal = 1'b0;
         if (i != n - 1) repeat (half) tick();
      end
   endtask

   task automatic check_now(input string name, input int val, input logic ovf);
      @(negedge clk);
      check({name, ".seg"}, {25'd0, seg}, {24'd0, exp_seg(val, ovf, digit_sel)});
      check({name, ".ovf"}, {31'd0, overflow}, {31'd0, ovf});
   endtask

   task automatic check_display(input string name, input int val, input logic ovf);
      logic ok;
      logic [DIGITS-1:0] seen;
      ok   = 1'b1;
      seen = '0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if ({1'b0, seg} !== exp_seg(val, ovf, digit_sel) || overflow !== ovf) ok = 1'b0;
         seen = seen | digit_sel;
      end
      check(name, {29'd0, ok, seen}, {29'd0, 1'b1, 2'b11});
   endtask

   initial begin
      int t0;
      int t_next;
      int prev_val;
      logic prev_ovf;

      // period, reload, edges, half-period, expected display, expected overflow
      tbl[0] = '{100,  1'b1, 10,  5, 10, 1'b0};
      tbl[1] = '{1000, 1'b1, 200, 2, 99, 1'b1};
      tbl[2] = '{1000, 1'b0, 50,  2, 50, 1'b0};
      tbl[3] = '{1000, 1'b0, 99,  2, 99, 1'b0};
      tbl[4] = '{1000, 1'b0, 100, 2, 99, 1'b1};
      tbl[5] = '{2,    1'b1, 0,   1, 0,  1'b0};
      tbl[6] = '{20,   1'b1, 3,   2, 3,  1'b0};
      prev_val = 0;
      prev_ovf = 1'b0;
      t0 = 0;
      t_next = 0;

      repeat (3) @(posedge clk);
      #1;
      check("rst.seg", {25'd0, seg}, 32'h3F);
      check("rst.digit_sel", {30'd0, digit_sel}, 32'd1);
      check("rst.ovf", {31'd0, overflow}, 32'd0);
      check("rst.dbg_state", {30'd0, dbg_state}, {30'd0, GATE_ENC});
      check("rst.dbg_edge", {31'd0, dbg_edge}, 32'd0);
      rst_n = 1'b1;
      ena   = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         if (tbl[i].reload) do_load(tbl[i].period, t0);
         else t0 = t_next;
         t_next = t0 + tbl[i].period;
         pulse_train(tbl[i].n_edges, tbl[i].half);
         wait_until(t0 + tbl[i].period - 1);
         check_now($sformatf("v%0d.pre", i), prev_val, prev_ovf);
         wait_until(t0 + tbl[i].period);
         check_now($sformatf("v%0d.post", i), tbl[i].exp_val, tbl[i].exp_ovf);
         check_display($sformatf("v%0d.disp", i), tbl[i].exp_val, tbl[i].exp_ovf);
         prev_val = tbl[i].exp_val;
         prev_ovf = tbl[i].exp_ovf;
      end

      // period=1 parks in IDLE: no counting, display frozen
      do_load(1, t0);
      @(negedge clk);
      check("idle.state", {30'd0, dbg_state}, 32'd0);
      pulse_train(20, 2);
      repeat (300) tick();
      check_display("idle.frozen", 3, 1'b0);
      do_load(200, t0);
      @(negedge clk);
      check("idle.resume_state", {30'd0, dbg_state}, {30'd0, GATE_ENC});
      pulse_train(7, 3);
      wait_until(t0 + 199);
      check_now("idle.pre", 3, 1'b0);
      wait_until(t0 + 200);
      check_now("idle.post", 7, 1'b0);

      // edge pulse landing in the LATCH cycle belongs to the next window
      do_load(20, t0);
      pulse_train(3, 2);
      wait_until(t0 + 16);
      signal = 1'b1;
      wait_until(t0 + 19);
      check_now("latch_edge.pre", 7, 1'b0);
      wait_until(t0 + 20);
      check_now("latch_edge.w1", 3, 1'b0);
      signal = 1'b0;
      wait_until(t0 + 40);
      check_now("latch_edge.w2", 1, 1'b0);

      // asynchronous reset mid-window
      do_load(300, t0);
      pulse_train(120, 1);
      wait_until(t0 + 300);
      check_now("arst.pre_ovf", 0, 1'b1);
      pulse_train(37, 1);
      repeat (4) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst.seg", {25'd0, seg}, 32'h3F);
      check("arst.digit_sel", {30'd0, digit_sel}, 32'd1);
      check("arst.ovf", {31'd0, overflow}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      t0 = cyc;
      pulse_train(42, 1);
      wait_until(t0 + PERIOD_RST - 1);
      check_now("arst.pre_latch", 0, 1'b0);
      wait_until(t0 + PERIOD_RST);
      check_now("arst.first_latch", 42, 1'b0);

      // ena low for 500 clocks mid-window
      do_load(100, t0);
      pulse_train(5, 2);
      wait_until(t0 + 21);
      ena = 1'b0;
      pulse_train(10, 2);
      wait_until(t0 + 300);
      check_now("ena.hold", 42, 1'b0);
      wait_until(t0 + 521);
      ena = 1'b1;
      pulse_train(3, 2);
      wait_until(t0 + 599);
      check_now("ena.pre", 42, 1'b0);
      wait_until(t0 + 600);
      check_now("ena.post", 8, 1'b0);

`ifndef FREQ_COUNTER_DEBUG_EN
      check("dbg.tied_zero", dbg_seen, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/frequency_counter_gen2.md
# frequency_counter_gen2

Second-generation frequency counter core: measures rising edges on an asynchronous input over a programmable gate window of system clocks, accumulates directly in BCD across a parametrised number of digits, and drives a time-multiplexed seven-segment display. It sits under the Tiny Tapeout top-level wrapper, replacing the fixed two-digit counter with one that adds overflow indication and a configurable digit count and synchroniser depth.

## Interface
Parameters:
- DIGITS, 2: number of BCD digits counted and displayed (1..4).
- PERIOD_W, 12: width of the gate-period register.
- PERIOD_RST, 1000: period register value after reset.
- SYNC_STAGES, 2: synchroniser flops on `signal` (>=2).
- MUX_DIV_W, 8: display digit advances every 2^MUX_DIV_W clocks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; when low, the FSM, counters and mux hold.
- signal  in  1  asynchronous measured input.
- period  in  PERIOD_W  new gate length in clocks.
- load_period  in  1  capture `period` and restart measurement.
- seg  out  7  active-high segments {g,f,e,d,c,b,a} of the selected digit.
- digit_sel  out  DIGITS  one-hot digit enable; bit 0 is the units digit.
- overflow  out  1  last completed window exceeded 10^DIGITS-1 edges.
- dbg_state  out  2  FSM state encoding.
- dbg_edge  out  1  registered edge-detect pulse.

## Operation
- `signal` passes through SYNC_STAGES flops, then one compare flop; `edge` = sync & ~prev.
- States: IDLE=0, GATE=1, LATCH=2. Reset enters GATE with period_reg=PERIOD_RST.
- GATE: window counter increments 0..period_reg-2; each `edge` increments the BCD counter (ripple carry between digits within one cycle). On window==period_reg-2, go to LATCH.
- LATCH (1 cycle): display_reg <= BCD count; overflow <= ovf_flag; BCD count <= (edge ? 1 : 0); ovf_flag <= 0; window <= 0; go to GATE. The gate window is exactly period_reg clocks, LATCH included.
- Saturation: an edge arriving while the count is all 9s leaves the count at all 9s and sets ovf_flag.
- load_period (highest priority over all states): period_reg <= period; BCD count, window and ovf_flag cleared; display_reg and overflow retained; next state GATE if period >= 2, else IDLE.
- IDLE: no counting, no latching; left only by load_period with period >= 2.
- Display: mux counter steps digit_sel one-hot left, wrapping at DIGITS. seg = standard 0-9 decode of the selected digit of display_reg (0 -> 7'h3F, 1 -> 7'h06, 8 -> 7'h7F). When overflow=1, every digit shows 7'h40 (dash).
- Unused encoding 3 of the state register recovers to GATE.

## Timing
- Reset values: seg=7'h3F, digit_sel=1, overflow=0, dbg_state=1, dbg_edge=0; display_reg=0, period_reg=PERIOD_RST.
- Edge latency: a rising `signal` sampled at clock n asserts `edge` in the cycle after clock n+SYNC_STAGES.
- Maximum counted rate: one edge per 2 clocks; faster inputs alias.
- Display update: display_reg, overflow and seg change on the clock ending LATCH.
- load_period coinciding with LATCH: load wins; no latch occurs.
- ena low: all state frozen, outputs hold last values; synchroniser keeps running.
- Reset asserted mid-window: all outputs return to reset values immediately.

## Configuration
- FREQ_COUNTER_DEBUG_EN defined: dbg_state and dbg_edge drive the FSM state and edge pulse.
- Undefined: both outputs tied to 0 and the related logic removed; counting behaviour is unchanged.

## Test plan
- Reset, DIGITS=2, load period=100, square wave at clk/10 -> after the first full window, display_reg=10, seg on units=7'h3F, on tens=7'h06, overflow=0.
- period=1000, signal at clk/4 (250 edges), DIGITS=2 -> overflow=1, all digits show 7'h40; the next window with 50 edges -> overflow=0, display 50.
- load_period with period=1 -> dbg_state=0, display frozen; load 200 -> GATE resumes, the first latch occurs 200 clocks later.
- Edge arriving exactly in the LATCH cycle -> counted in the next window (period=20, edges timed at the boundary; expect count carried as 1).
- Assert rst_n mid-window with count 37 -> seg=7'h3F, digit_sel=1, overflow=0 immediately; first post-reset latch at PERIOD_RST clocks.
- ena held low for 500 clocks mid-window -> window and count frozen; resumes without loss after ena rises; with the macro undefined, dbg_state and dbg_edge are constantly 0.
